// File: rtl/tracker_pkg.sv
// Shared constants and types for the multi-colour tracker: coordinate width,
// reset extrema, counter width and corner encoding.
package tracker_pkg;

  localparam int COORD_W = 10;
  localparam int CNT_W   = 19;

  localparam logic [COORD_W-1:0] X_MIN_INIT = 10'd639;
  localparam logic [COORD_W-1:0] Y_MIN_INIT = 10'd479;
  localparam logic [COORD_W-1:0] COORD_ZERO = 10'd0;

  typedef enum logic [2:0] {
    CORNER_NONE = 3'd0,
    CORNER_TL   = 3'd1,
    CORNER_TR   = 3'd2,
    CORNER_BL   = 3'd3,
    CORNER_BR   = 3'd4
  } corner_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  localparam point_t POINT_ZERO = 20'd0;

endpackage

// File: rtl/color_channel_tracker.sv
// One colour channel: chroma window match, history popcount qualification,
// running bounding box with corner capture, and frame-end snapshot.
// Optional qualified-pixel counting under TRACKER_PIXCOUNT_EN.
module color_channel_tracker
  import tracker_pkg::*;
#(
  parameter int HIST_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            cb,
  input  logic [7:0]            cr,
  input  logic [7:0]            cb_lo,
  input  logic [7:0]            cb_hi,
  input  logic [7:0]            cr_lo,
  input  logic [7:0]            cr_hi,
  input  logic [HIST_DEPTH-1:0] history,
  input  logic [3:0]            threshold,
  input  logic                  pix_ok,
  input  logic                  snap,
  input  logic [COORD_W-1:0]    x,
  input  logic [COORD_W-1:0]    y,
`ifdef TRACKER_PIXCOUNT_EN
  input  logic [CNT_W-1:0]      min_count,
  output logic [CNT_W-1:0]      pix_count,
`endif
  output logic                  match,
  output logic                  qual,
  output point_t                prev_tl,
  output point_t                prev_tr,
  output point_t                prev_bl,
  output point_t                prev_br,
  output logic [COORD_W-1:0]    box_x_min,
  output logic [COORD_W-1:0]    box_x_max,
  output logic [COORD_W-1:0]    box_y_min,
  output logic [COORD_W-1:0]    box_y_max,
  output logic                  box_valid
);

  function automatic logic [3:0] popcount(input logic [HIST_DEPTH-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      cnt = cnt + {3'd0, v[i]};
    end
    return cnt;
  endfunction

  logic [COORD_W-1:0] run_x_min, run_x_max, run_y_min, run_y_max;
  point_t             run_tl, run_tr, run_bl, run_br;
  logic               run_any;
  point_t             cur;
  logic               frame_ok;

  assign cur = {x, y};

  // Window match and qualification against history strength
  always_comb begin
    match = 1'b0;
    qual  = 1'b0;
    if ((cb >= cb_lo) && (cb <= cb_hi) && (cr >= cr_lo) && (cr <= cr_hi)) begin
      match = 1'b1;
    end else begin
      match = 1'b0;
    end
    qual = match && pix_ok && (popcount(history) > threshold);
  end

`ifdef TRACKER_PIXCOUNT_EN
  logic [CNT_W-1:0] run_count;

  // Saturating qualified-pixel counter with frame-end snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      run_count <= 19'd0;
      pix_count <= 19'd0;
    end else if (snap) begin
      pix_count <= run_count;
      run_count <= 19'd0;
    end else if (qual && (run_count != 19'h7FFFF)) begin
      run_count <= run_count + 19'd1;
    end
  end

  assign frame_ok = run_any && (run_count >= min_count);
`else
  assign frame_ok = run_any;
`endif

  // Running box / corners, snapshot into the reported box at frame end
  always_ff @(posedge clk) begin
    if (reset) begin
      run_x_min <= X_MIN_INIT;
      run_x_max <= COORD_ZERO;
      run_y_min <= Y_MIN_INIT;
      run_y_max <= COORD_ZERO;
      run_tl    <= POINT_ZERO;
      run_tr    <= POINT_ZERO;
      run_bl    <= POINT_ZERO;
      run_br    <= POINT_ZERO;
      run_any   <= 1'b0;
      prev_tl   <= POINT_ZERO;
      prev_tr   <= POINT_ZERO;
      prev_bl   <= POINT_ZERO;
      prev_br   <= POINT_ZERO;
      box_x_min <= X_MIN_INIT;
      box_x_max <= COORD_ZERO;
      box_y_min <= Y_MIN_INIT;
      box_y_max <= COORD_ZERO;
      box_valid <= 1'b0;
    end else if (snap) begin
      box_x_min <= run_x_min;
      box_x_max <= run_x_max;
      box_y_min <= run_y_min;
      box_y_max <= run_y_max;
      box_valid <= frame_ok;
      prev_tl   <= run_tl;
      prev_tr   <= run_tr;
      prev_bl   <= run_bl;
      prev_br   <= run_br;
      run_x_min <= X_MIN_INIT;
      run_x_max <= COORD_ZERO;
      run_y_min <= Y_MIN_INIT;
      run_y_max <= COORD_ZERO;
      run_tl    <= POINT_ZERO;
      run_tr    <= POINT_ZERO;
      run_bl    <= POINT_ZERO;
      run_br    <= POINT_ZERO;
      run_any   <= 1'b0;
    end else if (qual) begin
      // Non-strict compares so a later pixel wins ties
      run_any <= 1'b1;
      if (x <= run_x_min) begin
        run_x_min <= x;
        run_tl    <= cur;
      end
      if (x >= run_x_max) begin
        run_x_max <= x;
        run_br    <= cur;
      end
      if (y <= run_y_min) begin
        run_y_min <= y;
        run_tr    <= cur;
      end
      if (y >= run_y_max) begin
        run_y_max <= y;
        run_bl    <= cur;
      end
    end
  end

endmodule

// File: rtl/multi_color_tracker.sv
// Multi-channel colour tracker top: VS falling-edge detection, per-pixel
// registered outputs and corner arbitration. Optional TRACKER_PIXCOUNT_EN
// adds per-channel qualified-pixel counts and a min_count gate on box_valid.
module multi_color_tracker
  import tracker_pkg::*;
#(
  parameter int NUM_COLORS = 2,
  parameter int HIST_DEPTH = 4,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 19
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             VGA_VS,
  input  logic [7:0]                       Cb,
  input  logic [7:0]                       Cr,
  input  logic                             pix_valid,
  input  logic [ADDR_W-1:0]                read_addr,
  input  logic [COORD_W-1:0]               read_x,
  input  logic [COORD_W-1:0]               read_y,
  input  logic [NUM_COLORS*HIST_DEPTH-1:0] color_history,
  input  logic [NUM_COLORS*8-1:0]          cb_lo,
  input  logic [NUM_COLORS*8-1:0]          cb_hi,
  input  logic [NUM_COLORS*8-1:0]          cr_lo,
  input  logic [NUM_COLORS*8-1:0]          cr_hi,
  input  logic [3:0]                       threshold_history,
`ifdef TRACKER_PIXCOUNT_EN
  input  logic [CNT_W-1:0]                 min_count,
  output logic [NUM_COLORS*CNT_W-1:0]      pix_count,
`endif
  output logic [NUM_COLORS-1:0]            pix_match,
  output logic [2:0]                       corner_code,
  output logic [2:0]                       corner_chan,
  output logic [NUM_COLORS*HIST_DEPTH-1:0] updated_color_history,
  output logic                             we,
  output logic [ADDR_W-1:0]                write_addr,
  output logic [NUM_COLORS*COORD_W-1:0]    box_x_min,
  output logic [NUM_COLORS*COORD_W-1:0]    box_x_max,
  output logic [NUM_COLORS*COORD_W-1:0]    box_y_min,
  output logic [NUM_COLORS*COORD_W-1:0]    box_y_max,
  output logic [NUM_COLORS-1:0]            box_valid,
  output logic                             frame_done
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_ACTIVE);

  logic                             vs_d;
  logic                             vs_fall;
  logic                             pix_take;
  logic                             pix_ok;
  logic [NUM_COLORS-1:0]            match;
  logic [NUM_COLORS-1:0]            qual;
  logic [NUM_COLORS*HIST_DEPTH-1:0] hist_next;
  point_t                           prev_tl [NUM_COLORS];
  point_t                           prev_tr [NUM_COLORS];
  point_t                           prev_bl [NUM_COLORS];
  point_t                           prev_br [NUM_COLORS];
  point_t                           cur;
  corner_e                          code_next;
  logic [2:0]                       chan_next;
  logic                             found;

  // A pixel landing on the frame-end cycle is dropped entirely
  assign vs_fall  = vs_d & ~VGA_VS;
  assign pix_take = pix_valid & ~vs_fall;
  assign pix_ok   = pix_take && (read_x < X_LIM) && (read_y < Y_LIM);
  assign cur      = {read_x, read_y};

  for (genvar k = 0; k < NUM_COLORS; k++) begin : gen_chan
    color_channel_tracker #(.HIST_DEPTH(HIST_DEPTH)) u_chan (
      .clk       (clk),
      .reset     (reset),
      .cb        (Cb),
      .cr        (Cr),
      .cb_lo     (cb_lo[k*8 +: 8]),
      .cb_hi     (cb_hi[k*8 +: 8]),
      .cr_lo     (cr_lo[k*8 +: 8]),
      .cr_hi     (cr_hi[k*8 +: 8]),
      .history   (color_history[k*HIST_DEPTH +: HIST_DEPTH]),
      .threshold (threshold_history),
      .pix_ok    (pix_ok),
      .snap      (vs_fall),
      .x         (read_x),
      .y         (read_y),
`ifdef TRACKER_PIXCOUNT_EN
      .min_count (min_count),
      .pix_count (pix_count[k*CNT_W +: CNT_W]),
`endif
      .match     (match[k]),
      .qual      (qual[k]),
      .prev_tl   (prev_tl[k]),
      .prev_tr   (prev_tr[k]),
      .prev_bl   (prev_bl[k]),
      .prev_br   (prev_br[k]),
      .box_x_min (box_x_min[k*COORD_W +: COORD_W]),
      .box_x_max (box_x_max[k*COORD_W +: COORD_W]),
      .box_y_min (box_y_min[k*COORD_W +: COORD_W]),
      .box_y_max (box_y_max[k*COORD_W +: COORD_W]),
      .box_valid (box_valid[k])
    );
    assign hist_next[k*HIST_DEPTH +: HIST_DEPTH] =
      {color_history[k*HIST_DEPTH +: HIST_DEPTH-1], match[k]};
  end

  // Corner lookup against the lowest-index qualified channel
  always_comb begin
    code_next = CORNER_NONE;
    chan_next = 3'd0;
    found     = 1'b0;
    for (int k = 0; k < NUM_COLORS; k++) begin
      if (qual[k] && !found) begin
        found     = 1'b1;
        chan_next = 3'(k);
        if (cur == prev_tl[k]) begin
          code_next = CORNER_TL;
        end else if (cur == prev_tr[k]) begin
          code_next = CORNER_TR;
        end else if (cur == prev_bl[k]) begin
          code_next = CORNER_BL;
        end else if (cur == prev_br[k]) begin
          code_next = CORNER_BR;
        end else begin
          code_next = CORNER_NONE;
        end
      end else begin
        found = found;
      end
    end
  end

  // Per-pixel output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_d                  <= 1'b0;
      pix_match             <= {NUM_COLORS{1'b0}};
      corner_code           <= CORNER_NONE;
      corner_chan           <= 3'd0;
      we                    <= 1'b0;
      write_addr            <= {ADDR_W{1'b0}};
      updated_color_history <= {(NUM_COLORS*HIST_DEPTH){1'b0}};
      frame_done            <= 1'b0;
    end else begin
      vs_d        <= VGA_VS;
      pix_match   <= qual;
      corner_code <= code_next;
      corner_chan <= chan_next;
      we          <= pix_take;
      frame_done  <= vs_fall;
      if (pix_take) begin
        write_addr            <= read_addr;
        updated_color_history <= hist_next;
      end
    end
  end

endmodule

// File: tb/tb_multi_color_tracker.sv
// Directed self-checking bench for multi_color_tracker (default parameters).
module tb_multi_color_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        VGA_VS;
  logic [7:0]  Cb, Cr;
  logic        pix_valid;
  logic [18:0] read_addr;
  logic [9:0]  read_x, read_y;
  logic [7:0]  color_history;
  logic [15:0] cb_lo, cb_hi, cr_lo, cr_hi;
  logic [3:0]  threshold_history;
  logic [1:0]  pix_match;
  logic [2:0]  corner_code, corner_chan;
  logic [7:0]  updated_color_history;
  logic        we;
  logic [18:0] write_addr;
  logic [19:0] box_x_min, box_x_max, box_y_min, box_y_max;
  logic [1:0]  box_valid;
  logic        frame_done;
`ifdef TRACKER_PIXCOUNT_EN
  logic [18:0] min_count;
  logic [37:0] pix_count;
`endif

  int total = 0;
  int bad   = 0;

  multi_color_tracker dut (
    .clk(clk), .reset(reset), .VGA_VS(VGA_VS), .Cb(Cb), .Cr(Cr),
    .pix_valid(pix_valid), .read_addr(read_addr), .read_x(read_x), .read_y(read_y),
    .color_history(color_history), .cb_lo(cb_lo), .cb_hi(cb_hi), .cr_lo(cr_lo),
    .cr_hi(cr_hi), .threshold_history(threshold_history),
`ifdef TRACKER_PIXCOUNT_EN
    .min_count(min_count), .pix_count(pix_count),
`endif
    .pix_match(pix_match), .corner_code(corner_code), .corner_chan(corner_chan),
    .updated_color_history(updated_color_history), .we(we), .write_addr(write_addr),
    .box_x_min(box_x_min), .box_x_max(box_x_max), .box_y_min(box_y_min),
    .box_y_max(box_y_max), .box_valid(box_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; VGA_VS = 1'b1; pix_valid = 1'b0; Cb = 8'd50; Cr = 8'd200;
    read_x = 10'd0; read_y = 10'd0; read_addr = 19'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic put_pixel(input int x, input int y);
    pix_valid = 1'b1; read_x = 10'(x); read_y = 10'(y); read_addr = 19'(y * 640 + x);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic vs_fall;
    VGA_VS = 1'b0;
    tick();
    VGA_VS = 1'b1;
  endtask

  task automatic frame_one;
    color_history = 8'b0000_1111;
    put_pixel(10, 20); put_pixel(300, 5); put_pixel(600, 400);
    vs_fall(); tick();
  endtask

  task automatic test_reset;
    do_reset(); tick();
    total++; if (pix_match !== 2'b00) begin bad++; $display("FAIL rst_pix_match got=%b exp=00", pix_match); end
    total++; if (corner_code !== 3'd0) begin bad++; $display("FAIL rst_corner_code got=%0d exp=0", corner_code); end
    total++; if (corner_chan !== 3'd0) begin bad++; $display("FAIL rst_corner_chan got=%0d exp=0", corner_chan); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", we); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
    total++; if (write_addr !== 19'd0) begin bad++; $display("FAIL rst_write_addr got=%0d exp=0", write_addr); end
    total++; if (updated_color_history !== 8'h00) begin bad++; $display("FAIL rst_hist got=%h exp=00", updated_color_history); end
    total++; if (box_valid !== 2'b00) begin bad++; $display("FAIL rst_box_valid got=%b exp=00", box_valid); end
    total++; if (box_x_min !== {10'd639, 10'd639}) begin bad++; $display("FAIL rst_box_x_min got=%h", box_x_min); end
    total++; if (box_y_min !== {10'd479, 10'd479}) begin bad++; $display("FAIL rst_box_y_min got=%h", box_y_min); end
    total++; if ((box_x_max !== 20'd0) || (box_y_max !== 20'd0)) begin bad++; $display("FAIL rst_box_max got=%h/%h exp=0", box_x_max, box_y_max); end
  endtask

  task automatic test_frame_box;
    do_reset();
    color_history = 8'b0000_1111;
    put_pixel(10, 20);
    total++; if (we !== 1'b1) begin bad++; $display("FAIL box_we got=%b exp=1", we); end
    total++; if (pix_match !== 2'b01) begin bad++; $display("FAIL box_pix_match got=%b exp=01", pix_match); end
    total++; if (write_addr !== 19'd12810) begin bad++; $display("FAIL box_write_addr got=%0d exp=12810", write_addr); end
    total++; if (updated_color_history !== 8'b0001_1111) begin bad++; $display("FAIL box_hist got=%b exp=00011111", updated_color_history); end
    total++; if (corner_code !== 3'd0) begin bad++; $display("FAIL box_corner got=%0d exp=0", corner_code); end
    put_pixel(300, 5); put_pixel(600, 400);
    vs_fall();
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL box_frame_done got=%b exp=1", frame_done); end
    total++; if (box_x_min[9:0] !== 10'd10 || box_x_max[9:0] !== 10'd600) begin bad++; $display("FAIL box_x got=%0d..%0d exp=10..600", box_x_min[9:0], box_x_max[9:0]); end
    total++; if (box_y_min[9:0] !== 10'd5 || box_y_max[9:0] !== 10'd400) begin bad++; $display("FAIL box_y got=%0d..%0d exp=5..400", box_y_min[9:0], box_y_max[9:0]); end
    total++; if (box_valid !== 2'b01) begin bad++; $display("FAIL box_valid got=%b exp=01", box_valid); end
    total++; if (box_x_min[19:10] !== 10'd639) begin bad++; $display("FAIL box_ch1_xmin got=%0d exp=639", box_x_min[19:10]); end
    tick();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL box_frame_done_pulse got=%b exp=0", frame_done); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL box_we_idle got=%b exp=0", we); end
  endtask

  task automatic test_low_history;
    do_reset();
    color_history = 8'b0000_0011;
    put_pixel(10, 20);
    total++; if (pix_match !== 2'b00) begin bad++; $display("FAIL low_pix_match got=%b exp=00", pix_match); end
    total++; if (updated_color_history !== 8'b0001_0111) begin bad++; $display("FAIL low_hist got=%b exp=00010111", updated_color_history); end
    vs_fall();
    total++; if (box_valid !== 2'b00) begin bad++; $display("FAIL low_box_valid got=%b exp=00", box_valid); end
    total++; if (box_x_min[9:0] !== 10'd639) begin bad++; $display("FAIL low_box_xmin got=%0d exp=639", box_x_min[9:0]); end
  endtask

  task automatic test_corner;
    do_reset();
    frame_one();
    color_history = 8'b1111_1111;
    put_pixel(10, 20);
    total++; if (corner_code !== 3'd1 || corner_chan !== 3'd0) begin bad++; $display("FAIL corner_tl got=%0d/%0d exp=1/0", corner_code, corner_chan); end
    total++; if (pix_match !== 2'b11) begin bad++; $display("FAIL corner_pix_match got=%b exp=11", pix_match); end
    put_pixel(300, 5);
    total++; if (corner_code !== 3'd2) begin bad++; $display("FAIL corner_tr got=%0d exp=2", corner_code); end
    put_pixel(600, 400);
    total++; if (corner_code !== 3'd3) begin bad++; $display("FAIL corner_bl got=%0d exp=3", corner_code); end
    put_pixel(1, 1);
    total++; if (corner_code !== 3'd0) begin bad++; $display("FAIL corner_none got=%0d exp=0", corner_code); end
    color_history = 8'b1111_0000;
    put_pixel(10, 20);
    total++; if (corner_code !== 3'd0 || corner_chan !== 3'd1) begin bad++; $display("FAIL corner_ch1 got=%0d/%0d exp=0/1", corner_code, corner_chan); end
    put_pixel(640, 10);
    total++; if (pix_match !== 2'b00 || we !== 1'b1) begin bad++; $display("FAIL corner_range got=%b/%b exp=00/1", pix_match, we); end
    Cb = 8'd150;
    color_history = 8'b0000_1111;
    put_pixel(5, 5);
    total++; if (updated_color_history !== 8'b0000_1110) begin bad++; $display("FAIL corner_nomatch_hist got=%b exp=00001110", updated_color_history); end
    Cb = 8'd50;
  endtask

  task automatic test_vs_collision;
    do_reset();
    color_history = 8'b0000_1111;
    put_pixel(10, 20);
    pix_valid = 1'b1; read_x = 10'd5; read_y = 10'd5; read_addr = 19'd3205;
    VGA_VS = 1'b0;
    tick();
    pix_valid = 1'b0; VGA_VS = 1'b1;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL vs_we got=%b exp=0", we); end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL vs_frame_done got=%b exp=1", frame_done); end
    total++; if (box_x_min[9:0] !== 10'd10 || box_y_min[9:0] !== 10'd20) begin bad++; $display("FAIL vs_box got=%0d,%0d exp=10,20", box_x_min[9:0], box_y_min[9:0]); end
    tick();
    vs_fall();
    total++; if (box_valid !== 2'b00) begin bad++; $display("FAIL vs_next_valid got=%b exp=00", box_valid); end
  endtask

  task automatic test_reset_midframe;
    do_reset();
    color_history = 8'b0000_1111;
    put_pixel(10, 20);
    reset = 1'b1; tick(); reset = 1'b0; tick();
    put_pixel(300, 5);
    vs_fall();
    total++; if (box_x_min[9:0] !== 10'd300 || box_x_max[9:0] !== 10'd300) begin bad++; $display("FAIL mid_x got=%0d..%0d exp=300..300", box_x_min[9:0], box_x_max[9:0]); end
    total++; if (box_y_min[9:0] !== 10'd5 || box_valid !== 2'b01) begin bad++; $display("FAIL mid_y got=%0d/%b exp=5/01", box_y_min[9:0], box_valid); end
  endtask

`ifdef TRACKER_PIXCOUNT_EN
  task automatic test_pixcount;
    min_count = 19'd3;
    do_reset();
    color_history = 8'b0000_1111;
    put_pixel(10, 20); put_pixel(20, 30);
    vs_fall();
    total++; if (pix_count[18:0] !== 19'd2) begin bad++; $display("FAIL pc_count got=%0d exp=2", pix_count[18:0]); end
    total++; if (box_valid !== 2'b00) begin bad++; $display("FAIL pc_valid got=%b exp=00", box_valid); end
    min_count = 19'd0;
  endtask
`endif

  initial begin
    cb_lo = {8'd0, 8'd0};       cb_hi = {8'd100, 8'd100};
    cr_lo = {8'd150, 8'd150};   cr_hi = {8'd255, 8'd255};
    threshold_history = 4'd2;   color_history = 8'h00;
`ifdef TRACKER_PIXCOUNT_EN
    min_count = 19'd0;
`endif
    test_reset();
    test_frame_box();
    test_low_history();
    test_corner();
    test_vs_collision();
    test_reset_midframe();
`ifdef TRACKER_PIXCOUNT_EN
    test_pixcount();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_color_tracker.md
MULTI_COLOR_TRACKER -- requirements
Module: multi_color_tracker

Interface
REQ-001 SHALL have parameter NUM_COLORS, default 2, number of independent colour channels (1..8).
REQ-002 SHALL have parameter HIST_DEPTH, default 4, per-channel frame-history bits per pixel (2..8).
REQ-003 SHALL have parameters H_ACTIVE 640, V_ACTIVE 480, ADDR_W 19; coordinates are 10 bits unsigned.
REQ-004 SHALL have: clk  in  1  sole clock, all logic posedge.
REQ-005 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have: VGA_VS  in  1  vertical sync; its falling edge marks frame end.
REQ-007 SHALL have: Cb, Cr  in  8 each  pixel chroma; pix_valid  in  1  pixel qualifier.
REQ-008 SHALL have: read_addr  in  ADDR_W; read_x, read_y  in  10 each  pixel position.
REQ-009 SHALL have: color_history  in  NUM_COLORS*HIST_DEPTH  per-channel history, channel k at bits [k*HIST_DEPTH +: HIST_DEPTH].
REQ-010 SHALL have: cb_lo, cb_hi, cr_lo, cr_hi  in  NUM_COLORS*8 each  per-channel inclusive chroma window.
REQ-011 SHALL have: threshold_history  in  4  minimum history popcount (strictly exceeded).
REQ-012 SHALL have: pix_match  out  NUM_COLORS; corner_code  out  3 (NONE 0, TL 1, TR 2, BL 3, BR 4); corner_chan  out  3.
REQ-013 SHALL have: updated_color_history  out  NUM_COLORS*HIST_DEPTH; we  out  1; write_addr  out  ADDR_W.
REQ-014 SHALL have: box_x_min, box_x_max, box_y_min, box_y_max  out  NUM_COLORS*10 each; box_valid  out  NUM_COLORS; frame_done  out  1.

Function
REQ-015 SHALL compute raw match_k = cb_lo_k<=Cb<=cb_hi_k AND cr_lo_k<=Cr<=cr_hi_k.
REQ-016 SHALL qualify channel k only when match_k AND popcount(history_k) > threshold_history AND pix_valid AND read_x<H_ACTIVE AND read_y<V_ACTIVE.
REQ-017 SHALL register all per-pixel outputs with latency exactly 1 cycle from the input sample.
REQ-018 SHALL, per valid pixel, assert we=1, write_addr=read_addr, updated history_k = {history_k[HIST_DEPTH-2:0], match_k}; we=0 otherwise.
REQ-019 SHALL update per-channel running x_min/x_max/y_min/y_max on qualified pixels; ties (<=, >=) take the later pixel.
REQ-020 SHALL latch corners: TL at x_min update, BR at x_max, TR at y_min, BL at y_max (position of updating pixel).
REQ-021 SHALL set corner_code by comparing the pixel against previous-frame corners of the lowest-index qualified channel, priority TL>TR>BL>BR, else NONE; corner_chan = that channel index.
REQ-022 SHALL, on VS falling edge, copy running boxes to box_* outputs, pulse frame_done for one cycle, and reinitialise running state (min 639/479, max 0, corners 0).
REQ-023 SHALL, when a pixel coincides with the VS falling-edge cycle, perform the snapshot and drop the pixel (we=0, no box update).
REQ-024 SHALL set box_valid_k=1 only if channel k had at least one qualified pixel that frame.

Reset
REQ-025 SHALL, on reset, clear pix_match, corner_code, corner_chan, we, frame_done, write_addr, updated_color_history, box_valid, box_x_max, box_y_max to 0, and set box_x_min 639, box_y_min 479.
REQ-026 SHALL, on reset mid-frame, discard running state; the next VS falling edge reports only post-reset pixels.

Configuration
REQ-027 SHALL, with TRACKER_PIXCOUNT_EN defined, keep a 19-bit saturating qualified-pixel count per channel, output pix_count (NUM_COLORS*19) snapshotted at frame end, and require count >= input min_count (19) for box_valid.
REQ-028 SHALL, without TRACKER_PIXCOUNT_EN, omit pix_count and min_count ports and use REQ-024 rule.

Structure
REQ-029 SHALL place corner codes, coordinate width and reset extrema constants in package tracker_pkg.
REQ-030 SHALL instantiate one color_channel_tracker per channel (window match, popcount, running box, snapshot); top holds VS edge detect and corner arbitration.

Verification
REQ-031 Reset then idle -> all outputs at REQ-025 values, we=0.
REQ-032 Channel 0 window Cb 0..100, Cr 150..255, history 4'b1111, threshold 2, pixels (10,20),(300,5),(600,400) then VS fall -> box0 x 10..600, y 5..400, box_valid=01, frame_done one cycle.
REQ-033 Same as REQ-032 but history 4'b0011 -> pix_match 0, box_valid=00, updated history 4'b0111.
REQ-034 Next frame pixel at prior TL (10,20) matching both channels -> corner_code 1, corner_chan 0.
REQ-035 Pixel with pix_valid=1 on VS falling-edge cycle -> we=0, pixel absent from next snapshot.
REQ-036 With TRACKER_PIXCOUNT_EN, min_count 3, two qualified pixels -> pix_count 2, box_valid 0.
